// File: rtl/wb_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_write_arbiter_pkg
// Purpose : Register-file write-port types shared by regfile, decode and the
//           writeback arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package wb_write_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam int WB_DATA_W = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic                 live;
        reg_addr_t            addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    // r0 is hardwired to zero, so writes aimed at it never reach the file.
    function automatic logic is_real_reg(input reg_addr_t a);
        return a != REG_ZERO;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : wb_write_arbiter_if
// Purpose : Writeback sources, hazard query and register-file write port.
// Rev     : 1.0  initial release
// ============================================================================
interface wb_write_arbiter_if
    import wb_write_arbiter_pkg::*;
#(
    parameter int bit_size = 32,
    parameter int DEPTH    = 4
);
    logic                      alu_we;
    reg_addr_t                 alu_addr;
    logic [bit_size-1:0]       alu_data;
    logic                      lsu_valid;
    logic                      lsu_ready;
    reg_addr_t                 lsu_addr;
    logic [bit_size-1:0]       lsu_data;
    reg_addr_t                 Read_addr_1;
    reg_addr_t                 Read_addr_2;
    logic                      pend_hit_1;
    logic                      pend_hit_2;
    logic                      RegWrite;
    reg_addr_t                 Write_addr;
    logic [bit_size-1:0]       Write_data;
    logic [$clog2(DEPTH):0]    occupancy;

    modport slave (
        input  alu_we, alu_addr, alu_data,
        input  lsu_valid, lsu_addr, lsu_data,
        input  Read_addr_1, Read_addr_2,
        output lsu_ready, pend_hit_1, pend_hit_2,
        output RegWrite, Write_addr, Write_data, occupancy
    );

    modport master (
        output alu_we, alu_addr, alu_data,
        output lsu_valid, lsu_addr, lsu_data,
        output Read_addr_1, Read_addr_2,
        input  lsu_ready, pend_hit_1, pend_hit_2,
        input  RegWrite, Write_addr, Write_data, occupancy
    );
endinterface
`default_nettype wire

// File: rtl/wb_write_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module  : wb_fifo
// Purpose : In-order load-writeback queue with per-entry live bits, an
//           associative kill port and two associative match ports.
// Rev     : 1.0  initial release
// ============================================================================
module wb_fifo
    import wb_write_arbiter_pkg::*;
#(
    parameter int bit_size = 32,
    parameter int DEPTH    = 4,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int OCC_W   = PTR_W + 1
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                push,
    input  wire reg_addr_t           push_addr,
    input  wire logic [bit_size-1:0] push_data,
    input  wire logic                pop,
    input  wire logic                kill_en,
    input  wire reg_addr_t           kill_addr,
    input  wire reg_addr_t           match_addr_1,
    input  wire reg_addr_t           match_addr_2,
    output logic                     full,
    output logic                     empty,
    output logic                     head_live,
    output reg_addr_t                head_addr,
    output logic [bit_size-1:0]      head_data,
    output logic [OCC_W-1:0]         occupancy,
    output logic                     hit_1,
    output logic                     hit_2
);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic [DEPTH-1:0]    live_q, live_d;
    reg_addr_t           addr_q [DEPTH];
    reg_addr_t           addr_d [DEPTH];
    logic [bit_size-1:0] data_q [DEPTH];
    logic [bit_size-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic                push_ok, pop_ok;

    assign full      = (occ_q == OCC_FULL);
    assign empty     = (occ_q == '0);
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_live = live_q[rd_ptr_q];
    assign head_addr = addr_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];
    assign occupancy = occ_q;

    always_comb begin
        live_d   = live_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        // Free slots are never live, so the kill can sweep every slot.
        if (kill_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr_q[i] == kill_addr) live_d[i] = 1'b0;
            end
        end
        if (pop_ok) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + PTR_W'(1);
        end
        // Applied after the kill: a same-cycle beat is younger than the ALU write.
        if (push_ok) begin
            live_d[wr_ptr_q] = 1'b1;
            addr_d[wr_ptr_q] = push_addr;
            data_d[wr_ptr_q] = push_data;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        hit_1 = 1'b0;
        hit_2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && addr_q[i] == match_addr_1) hit_1 = 1'b1;
            if (live_q[i] && addr_q[i] == match_addr_2) hit_2 = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            live_q   <= live_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Payload is only meaningful under a live bit, so it needs no reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule
`default_nettype wire

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : wb_write_arbiter
// Purpose : Merges ALU and load-unit writebacks onto the single register-file
//           write port and flags pending-write hazards for decode.
// Rev     : 1.0  initial release
// ============================================================================
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int bit_size = 32,
    parameter int DEPTH    = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    wb_write_arbiter_if.slave   bus
);
    logic                      alu_eff;
    logic                      lsu_ready;
    logic                      push;
    logic                      pop;
    logic                      full;
    logic                      empty;
    logic                      head_live;
    reg_addr_t                 head_addr;
    logic [bit_size-1:0]       head_data;
    logic [$clog2(DEPTH):0]    occupancy;
    logic                      hit_1;
    logic                      hit_2;

    // Qualifying with rst keeps the port quiet while the queue is held in reset.
    assign alu_eff   = rst && bus.alu_we && is_real_reg(bus.alu_addr);
    assign lsu_ready = rst && !full;
    assign push      = bus.lsu_valid && lsu_ready && is_real_reg(bus.lsu_addr);
    assign pop       = rst && !alu_eff && !empty;

    wb_fifo #(
        .bit_size (bit_size),
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_addr    (bus.lsu_addr),
        .push_data    (bus.lsu_data),
        .pop          (pop),
        .kill_en      (alu_eff),
        .kill_addr    (bus.alu_addr),
        .match_addr_1 (bus.Read_addr_1),
        .match_addr_2 (bus.Read_addr_2),
        .full         (full),
        .empty        (empty),
        .head_live    (head_live),
        .head_addr    (head_addr),
        .head_data    (head_data),
        .occupancy    (occupancy),
        .hit_1        (hit_1),
        .hit_2        (hit_2)
    );

    always_comb begin
        bus.RegWrite   = 1'b0;
        bus.Write_addr = REG_ZERO;
        bus.Write_data = '0;
        if (alu_eff) begin
            bus.RegWrite   = 1'b1;
            bus.Write_addr = bus.alu_addr;
            bus.Write_data = bus.alu_data;
        end else if (pop && head_live) begin
            bus.RegWrite   = 1'b1;
            bus.Write_addr = head_addr;
            bus.Write_data = head_data;
        end
    end

    assign bus.lsu_ready  = lsu_ready;
    assign bus.occupancy  = occupancy;
    assign bus.pend_hit_1 = rst && is_real_reg(bus.Read_addr_1) && hit_1;
    assign bus.pend_hit_2 = rst && is_real_reg(bus.Read_addr_2) && hit_2;

endmodule
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_write_arbiter
// Purpose : Directed self-checking bench for wb_write_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
module tb_wb_write_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic tb_clr;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] rf [32];
    logic [31:0] written;

    always #5 clk = ~clk;

    wb_write_arbiter_if #(.bit_size(32), .DEPTH(4)) bus ();

    wb_write_arbiter #(.bit_size(32), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Register file stand-in: captures the write port on each rising edge.
    always @(posedge clk) begin
        if (tb_clr) begin
            written <= '0;
        end else if (bus.RegWrite) begin
            rf[bus.Write_addr]      <= bus.Write_data;
            written[bus.Write_addr] <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_port(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_we"},   64'(bus.RegWrite),   64'(we));
        chk({tag, "_addr"}, 64'(bus.Write_addr), 64'(a));
        chk({tag, "_data"}, 64'(bus.Write_data), 64'(d));
    endtask

    initial begin
        rst             = 1'b0;
        tb_clr          = 1'b1;
        bus.alu_we      = 1'b1;
        bus.alu_addr    = 5'd4;
        bus.alu_data    = 32'h44;
        bus.lsu_valid   = 1'b1;
        bus.lsu_addr    = 5'd6;
        bus.lsu_data    = 32'h66;
        bus.Read_addr_1 = 5'd6;
        bus.Read_addr_2 = 5'd4;

        // Reset held with traffic present: everything must stay quiet.
        repeat (2) tick();
        #2;
        chk_port("rst_port", 1'b0, 5'd0, 32'h0);
        chk("rst_ready", 64'(bus.lsu_ready), 64'd0);
        chk("rst_occ",   64'(bus.occupancy), 64'd0);
        chk("rst_hit1",  64'(bus.pend_hit_1), 64'd0);
        chk("rst_hit2",  64'(bus.pend_hit_2), 64'd0);
        tick();

        bus.alu_we    = 1'b0;
        bus.lsu_valid = 1'b0;
        rst           = 1'b1;
        tb_clr        = 1'b0;
        #2;
        chk("exit_ready", 64'(bus.lsu_ready), 64'd1);
        chk("exit_occ",   64'(bus.occupancy), 64'd0);
        tick();

        // Single load beat with the ALU idle.
        bus.lsu_valid   = 1'b1;
        bus.lsu_addr    = 5'd5;
        bus.lsu_data    = 32'hDEADBEEF;
        bus.Read_addr_1 = 5'd5;
        #2;
        chk_port("ld_push", 1'b0, 5'd0, 32'h0);
        chk("ld_hit_incoming", 64'(bus.pend_hit_1), 64'd0);
        tick();
        bus.lsu_valid = 1'b0;
        #2;
        chk_port("ld_out", 1'b1, 5'd5, 32'hDEADBEEF);
        chk("ld_occ1", 64'(bus.occupancy), 64'd1);
        chk("ld_hit",  64'(bus.pend_hit_1), 64'd1);
        tick();
        #2;
        chk("ld_occ0", 64'(bus.occupancy), 64'd0);
        chk("ld_we0",  64'(bus.RegWrite), 64'd0);
        tick();

        // Fill under continuous ALU traffic, then drain in order.
        bus.alu_we      = 1'b1;
        bus.alu_addr    = 5'd3;
        bus.alu_data    = 32'h33;
        bus.Read_addr_2 = 5'd10;
        for (int i = 0; i < 4; i++) begin
            bus.lsu_valid = 1'b1;
            bus.lsu_addr  = 5'(8 + i);
            bus.lsu_data  = 32'h100 + 32'(i);
            #2;
            chk("fill_ready", 64'(bus.lsu_ready), 64'd1);
            chk_port("fill_alu", 1'b1, 5'd3, 32'h33);
            tick();
        end
        bus.lsu_addr = 5'd12;
        bus.lsu_data = 32'h10C;
        #2;
        chk("full_occ",   64'(bus.occupancy), 64'd4);
        chk("full_ready", 64'(bus.lsu_ready), 64'd0);
        chk("full_hit2",  64'(bus.pend_hit_2), 64'd1);
        tick();
        #2;
        chk("full_ready2", 64'(bus.lsu_ready), 64'd0);
        chk("full_occ2",   64'(bus.occupancy), 64'd4);
        tick();
        bus.alu_we = 1'b0;
        #2;
        chk_port("drain8", 1'b1, 5'd8, 32'h100);
        chk("drain8_ready", 64'(bus.lsu_ready), 64'd0);
        tick();
        #2;
        chk_port("drain9", 1'b1, 5'd9, 32'h101);
        chk("drain9_ready", 64'(bus.lsu_ready), 64'd1);
        chk("drain9_occ",   64'(bus.occupancy), 64'd3);
        tick();
        bus.lsu_valid = 1'b0;
        #2;
        chk_port("drain10", 1'b1, 5'd10, 32'h102);
        chk("drain10_occ", 64'(bus.occupancy), 64'd3);
        tick();
        #2;
        chk_port("drain11", 1'b1, 5'd11, 32'h103);
        chk("drain11_occ", 64'(bus.occupancy), 64'd2);
        tick();
        #2;
        chk_port("drain12", 1'b1, 5'd12, 32'h10C);
        chk("drain12_occ", 64'(bus.occupancy), 64'd1);
        tick();
        #2;
        chk_port("drain_idle", 1'b0, 5'd0, 32'h0);
        chk("drain_occ0", 64'(bus.occupancy), 64'd0);
        tick();

        // WAW kill: queued r7 is superseded by a younger ALU write.
        bus.alu_we      = 1'b1;
        bus.alu_addr    = 5'd1;
        bus.alu_data    = 32'h1;
        bus.lsu_valid   = 1'b1;
        bus.lsu_addr    = 5'd7;
        bus.lsu_data    = 32'h11;
        bus.Read_addr_1 = 5'd7;
        #2;
        chk("waw_hit_pre", 64'(bus.pend_hit_1), 64'd0);
        tick();
        bus.lsu_valid = 1'b0;
        bus.alu_addr  = 5'd7;
        bus.alu_data  = 32'h22;
        #2;
        chk("waw_hit_live", 64'(bus.pend_hit_1), 64'd1);
        chk_port("waw_alu", 1'b1, 5'd7, 32'h22);
        tick();
        bus.alu_we = 1'b0;
        #2;
        chk("waw_hit_killed", 64'(bus.pend_hit_1), 64'd0);
        chk("waw_occ1",       64'(bus.occupancy), 64'd1);
        chk_port("waw_pop_dead", 1'b0, 5'd0, 32'h0);
        tick();
        #2;
        chk("waw_occ0", 64'(bus.occupancy), 64'd0);
        chk("waw_rf7",  64'(rf[7]), 64'h22);
        tick();

        // Same-cycle push and ALU write to r9: pushed beat is younger.
        bus.alu_we      = 1'b1;
        bus.alu_addr    = 5'd9;
        bus.alu_data    = 32'hBB;
        bus.lsu_valid   = 1'b1;
        bus.lsu_addr    = 5'd9;
        bus.lsu_data    = 32'hAA;
        bus.Read_addr_2 = 5'd9;
        #2;
        chk_port("pk_alu", 1'b1, 5'd9, 32'hBB);
        chk("pk_hit_pre", 64'(bus.pend_hit_2), 64'd0);
        tick();
        bus.alu_we    = 1'b0;
        bus.lsu_valid = 1'b0;
        #2;
        chk_port("pk_fifo", 1'b1, 5'd9, 32'hAA);
        chk("pk_hit", 64'(bus.pend_hit_2), 64'd1);
        tick();
        #2;
        chk("pk_rf9", 64'(rf[9]), 64'hAA);
        chk("pk_occ", 64'(bus.occupancy), 64'd0);
        tick();

        // r0 filtering on both sources and on the hazard query.
        bus.alu_we      = 1'b1;
        bus.alu_addr    = 5'd0;
        bus.alu_data    = 32'h66;
        bus.lsu_valid   = 1'b1;
        bus.lsu_addr    = 5'd0;
        bus.lsu_data    = 32'h55;
        bus.Read_addr_1 = 5'd0;
        #2;
        chk_port("r0_port", 1'b0, 5'd0, 32'h0);
        chk("r0_hit1",  64'(bus.pend_hit_1), 64'd0);
        chk("r0_ready", 64'(bus.lsu_ready), 64'd1);
        tick();
        bus.alu_we    = 1'b0;
        bus.lsu_valid = 1'b0;
        #2;
        chk("r0_occ", 64'(bus.occupancy), 64'd0);
        chk("r0_we",  64'(bus.RegWrite), 64'd0);
        tick();

        // Reset mid-drain discards three queued writes.
        bus.alu_we   = 1'b1;
        bus.alu_addr = 5'd2;
        bus.alu_data = 32'h2;
        for (int i = 0; i < 3; i++) begin
            bus.lsu_valid = 1'b1;
            bus.lsu_addr  = 5'(13 + i);
            bus.lsu_data  = 32'h200 + 32'(i);
            tick();
        end
        bus.lsu_valid   = 1'b0;
        bus.Read_addr_1 = 5'd13;
        #2;
        chk("mid_occ3", 64'(bus.occupancy), 64'd3);
        chk("mid_hit",  64'(bus.pend_hit_1), 64'd1);
        tick();
        rst        = 1'b0;
        tb_clr     = 1'b1;
        bus.alu_we = 1'b0;
        #2;
        chk("mid_rst_occ",   64'(bus.occupancy), 64'd0);
        chk("mid_rst_ready", 64'(bus.lsu_ready), 64'd0);
        chk("mid_rst_hit",   64'(bus.pend_hit_1), 64'd0);
        chk_port("mid_rst_port", 1'b0, 5'd0, 32'h0);
        tick();
        rst    = 1'b1;
        tb_clr = 1'b0;
        #2;
        chk("mid_exit_ready", 64'(bus.lsu_ready), 64'd1);
        chk("mid_exit_occ",   64'(bus.occupancy), 64'd0);
        chk("mid_exit_we",    64'(bus.RegWrite), 64'd0);
        repeat (3) tick();
        chk("mid_no_writes", 64'(written), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Write-side arbiter for the CPU register file's single write port. Each cycle it merges two writeback sources into the register file's `RegWrite`/`Write_addr`/`Write_data` inputs:

- the ALU, which has fixed priority and no backpressure;
- the load/long-latency unit, which uses a valid/ready handshake into a small in-order FIFO.

It also reports pending-write hazards on the two read addresses so that decode can stall.

## Interface
- `bit_size`, 32: data width of register values.
- `DEPTH`, 4: FIFO entries for load-unit writes; must be a power of two and at least 2.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous and active-low.
- `alu_we`  input  1  ALU writeback request this cycle.
- `alu_addr`  input  5  ALU destination register.
- `alu_data`  input  bit_size  ALU result.
- `lsu_valid`  input  1  load unit offers a write.
- `lsu_ready`  output  1  FIFO can accept this cycle.
- `lsu_addr`  input  5  load destination register.
- `lsu_data`  input  bit_size  load data.
- `Read_addr_1`, `Read_addr_2`  input  5 each  decode-stage source registers.
- `pend_hit_1`, `pend_hit_2`  output  1 each  a live FIFO entry targets that read address.
- `RegWrite`  output  1  write strobe to the register file.
- `Write_addr`  output  5  register file write address.
- `Write_data`  output  bit_size  register file write data.
- `occupancy`  output  $clog2(DEPTH)+1  stored FIFO entries, live or killed.

## Operation
- **FIFO entry:** {live, addr[4:0], data}. Read and write pointers wrap modulo DEPTH; occupancy counts 0..DEPTH.
- **Ready:** `lsu_ready` = (occupancy != DEPTH), taken from registered state only.
- **Push:** a push occurs when `lsu_valid && lsu_ready`.
  - `lsu_addr == 0`: the beat is accepted and discarded (no push).
  - Otherwise the entry is pushed with live = 1.
- **ALU writes:** an ALU write is effective when `alu_we && alu_addr != 0`. `alu_we` to r0 is ignored entirely.
- **Port selection, combinational, in priority order:**
  1. Effective ALU write: `RegWrite`=1, port carries `alu_addr`/`alu_data`; the FIFO does not pop.
  2. Otherwise, FIFO non-empty with a live head: `RegWrite`=1, port carries the head; pop.
  3. Otherwise, FIFO non-empty with a killed head: `RegWrite`=0; pop (the cycle is consumed).
  4. Otherwise: `RegWrite`=0, `Write_addr`=0, `Write_data`=0.
- **WAW kill:** an effective ALU write clears the live bit of every entry stored before this edge whose addr equals `alu_addr`. The ALU result is younger than those entries.
- **Simultaneous push and kill:** a beat pushed in the same cycle as a matching ALU write is treated as younger and stays live.
- **Simultaneous push and pop:** occupancy is unchanged and both pointers advance.
- **Hazard outputs:** `pend_hit_k` = (`Read_addr_k` != 0) && (some stored entry is live with a matching addr). The check is combinational over stored entries only, not the incoming beat.
- **Ordering:** load-unit writes drain strictly in acceptance order.

## Timing
- **Reset:** asynchronous assertion clears pointers, occupancy, and all live bits. While `rst` is low:
  - `RegWrite`=0, `Write_addr`=0, `Write_data`=0;
  - `lsu_ready`=0;
  - `pend_hit_1`/`pend_hit_2`=0;
  - `occupancy`=0.
- **Reset exit:** `lsu_ready`=1 from the first cycle after `rst` deasserts.
- **Mid-operation reset:** reset mid-drain discards all queued writes; none reach the register file.
- **ALU path latency:** zero cycles; the port is combinational from `alu_*`, and the register file captures it on the same edge.
- **Load path latency:** a beat accepted at edge N reaches the port in cycle N+1 at the earliest (ALU idle). Each ALU cycle adds one cycle of delay.
- **Throughput:** one register-file write per cycle. With the FIFO full and the ALU writing every cycle, `lsu_ready` stays 0 indefinitely (no starvation guarantee).

## Structure
- **Shared package:** `REG_ADDR_W`=5 and `REG_ZERO`=5'd0, plus the entry struct type {live, addr, data}, for use by the register file, decode, and this block.
- **Sub-module `wb_fifo`:** storage, pointers, occupancy, per-entry live bits with an associative kill port, and two associative match ports.
- **Top level:** port mux, r0 filtering, and reset gating of outputs.

## Test plan
- **Reset exit and single load:** release `rst`, push a beat (addr 5, data 0xDEADBEEF) with ALU idle → `RegWrite`=1, addr 5, data 0xDEADBEEF in the next cycle; `occupancy` returns 0.
- **Fill and backpressure:** hold `alu_we`=1 (addr 3) every cycle and push 5 load beats (addr 8–12) → `lsu_ready`=0 after 4 pushes, `occupancy`=4. Release the ALU → writes for 8, 9, 10, 11 appear in order, then 12.
- **WAW kill:** queue addr 7 (0x11), then ALU writes addr 7 (0x22) → `pend_hit` on 7 drops, the killed head pops with `RegWrite`=0, and the register file holds 0x22.
- **Same-cycle push and kill:** push addr 9 (0xAA) in the same cycle as ALU addr 9 (0xBB) → ALU writes 0xBB now, FIFO writes 0xAA next cycle.
- **r0 filtering:** push addr 0 and ALU write addr 0 → no push, `RegWrite`=0, `occupancy` unchanged, `pend_hit` on read address 0 = 0.
- **Reset mid-drain:** with 3 entries queued, assert `rst` for 1 cycle → `occupancy`=0, no further writes, `lsu_ready`=1 after release.
